// File: rtl/banner_ctrl.sv
// End-of-game banner sequencer: slides a row of glyph slots down, blinks it,
// holds it, then pulses done. Also resolves which slot covers the current pixel.
module banner_ctrl #(
  parameter int unsigned BASE_X       = 248,
  parameter int unsigned TARGET_Y     = 200,
  parameter int unsigned SLIDE_STEP   = 4,
  parameter int unsigned SLOT_PITCH   = 32,
  parameter int unsigned CHAR_W       = 26,
  parameter int unsigned CHAR_H       = 40,
  parameter int unsigned NUM_SLOTS    = 3,
  parameter int unsigned BLINK_FRAMES = 15,
  parameter int unsigned BLINK_COUNT  = 3,
  parameter int unsigned HOLD_FRAMES  = 120
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        show_req,
  input  logic        cancel,
  input  logic        winner_in,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [31:0] char_start_x,
  output logic [31:0] char_start_y,
  output logic [1:0]  slot_sel,
  output logic        winner,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_MAX = (BLINK_FRAMES > HOLD_FRAMES) ? BLINK_FRAMES : HOLD_FRAMES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned TOGGLES = 2 * BLINK_COUNT;
  localparam int unsigned TW      = $clog2(TOGGLES + 1);

  typedef enum logic [1:0] {IDLE, SLIDE, BLINK, HOLD} state_t;

  state_t        state, state_n;
  logic [31:0]   cur_y, cur_y_n, step_y;
  logic [CW-1:0] frame_cnt, frame_n;
  logic [TW-1:0] toggle_cnt, toggle_n;
  logic          vis, vis_n, winner_n, done_n;
  logic [1:0]    sel_n;
  logic [31:0]   sx_n;

  assign busy         = (state != IDLE);
  assign char_start_y = cur_y;

  always_comb begin
    state_n  = state;
    cur_y_n  = cur_y;
    vis_n    = vis;
    winner_n = winner;
    frame_n  = frame_cnt;
    toggle_n = toggle_cnt;
    done_n   = 1'b0;
    step_y   = cur_y + SLIDE_STEP;
    // cancel overrides everything, including a request or tick in the same cycle
    if (cancel) begin
      state_n = IDLE;
      cur_y_n = '0;
      vis_n   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (show_req) begin
            state_n  = SLIDE;
            cur_y_n  = '0;
            vis_n    = 1'b1;
            winner_n = winner_in;
          end
        end
        SLIDE: begin
          if (frame_tick) begin
            if (step_y >= TARGET_Y) begin
              cur_y_n  = TARGET_Y;
              state_n  = BLINK;
              frame_n  = '0;
              toggle_n = '0;
              vis_n    = 1'b1;
            end else begin
              cur_y_n = step_y;
            end
          end
        end
        BLINK: begin
          if (frame_tick) begin
            if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
              frame_n  = '0;
              vis_n    = ~vis;
              toggle_n = toggle_cnt + TW'(1);
              if (toggle_cnt == TW'(TOGGLES - 1)) state_n = HOLD;
            end else begin
              frame_n = frame_cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          if (frame_tick) begin
            if (frame_cnt == CW'(HOLD_FRAMES - 1)) begin
              state_n = IDLE;
              frame_n = '0;
              done_n  = 1'b1;
            end else begin
              frame_n = frame_cnt + CW'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    int unsigned ox;
    ox    = 0;
    sel_n = '0;
    sx_n  = BASE_X;
    if (state != IDLE && vis && {22'b0, y} >= cur_y && {22'b0, y} < cur_y + CHAR_H) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        ox = BASE_X + i * SLOT_PITCH;
        if ({22'b0, x} >= ox && {22'b0, x} < ox + CHAR_W) begin
          sel_n = 2'(i + 1);
          sx_n  = ox;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      cur_y        <= '0;
      vis          <= 1'b0;
      winner       <= 1'b0;
      frame_cnt    <= '0;
      toggle_cnt   <= '0;
      done         <= 1'b0;
      slot_sel     <= '0;
      char_start_x <= BASE_X;
    end else begin
      state        <= state_n;
      cur_y        <= cur_y_n;
      vis          <= vis_n;
      winner       <= winner_n;
      frame_cnt    <= frame_n;
      toggle_cnt   <= toggle_n;
      done         <= done_n;
      slot_sel     <= sel_n;
      char_start_x <= sx_n;
    end
  end

endmodule
